// File: rtl/rf_pkg.sv
// Shared types and helpers for the integer register file and its scoreboard.
// Contents: rf_aw() address-width helper, rf_addr_t / rf_data_t, RF_ZERO_ADDR.
package rf_pkg;

    // Address width for a register count; never narrower than one bit.
    function automatic int rf_aw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int RF_XLEN = 32;
    localparam int RF_NREG = 32;
    localparam int RF_AW   = rf_aw(RF_NREG);

    typedef logic [RF_AW-1:0]   rf_addr_t;
    typedef logic [RF_XLEN-1:0] rf_data_t;

    localparam rf_addr_t RF_ZERO_ADDR = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a live count.
// Ports: i_clk, i_reset (sync, active-low), i_wr_en/i_wr_addr (clears),
//        i_iss_valid/i_iss_rd/o_iss_ready (sets), o_busy_vec, o_busy_cnt.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG = RF_NREG,
    parameter int NWR  = 2,
    parameter int AW   = rf_aw(NREG)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [NWR-1:0]  i_wr_en,
    input  logic [NWR*AW-1:0] i_wr_addr,
    input  logic            i_iss_valid,
    input  logic [AW-1:0]   i_iss_rd,
    output logic            o_iss_ready,
    output logic [NREG-1:0] o_busy_vec,
    output logic [AW:0]     o_busy_cnt
);

    localparam int CW = AW + 1;

    logic [NREG-1:0] r_busy;
    logic [CW-1:0]   r_cnt;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_busy_nxt;
    logic [CW-1:0]   w_drop;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_rd_nz;
    logic            w_fire;

    // Writes to x0 never clear anything, so bit 0 can never be set here.
    always_comb begin
        w_clr = '0;
        for (int w = 0; w < NWR; w++) begin
            if (i_wr_en[w] && i_wr_addr[w*AW +: AW] != AW'(RF_ZERO_ADDR))
                w_clr[i_wr_addr[w*AW +: AW]] = 1'b1;
        end
    end

    assign w_rd_nz     = (i_iss_rd != AW'(RF_ZERO_ADDR));
    assign o_iss_ready = i_reset &
                         (!w_rd_nz | !r_busy[i_iss_rd] | w_clr[i_iss_rd]);
    assign w_fire      = i_iss_valid & o_iss_ready & w_rd_nz;

    always_comb begin
        w_set           = '0;
        w_set[i_iss_rd] = w_fire;
    end

    // A set wins over a same-cycle clear of the same register.
    assign w_busy_nxt = (r_busy & ~w_clr) | w_set;

    // Only clears that hit an already-busy register reduce the count.
    always_comb begin
        w_drop = '0;
        for (int r = 0; r < NREG; r++)
            w_drop = w_drop + CW'(r_busy[r] & w_clr[r]);
    end

    assign w_cnt_nxt = r_cnt + CW'(w_fire) - w_drop;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_busy_vec = r_busy;
    assign o_busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with async reads, prioritised sync writes,
// optional write-to-read bypass and an integrated pending-write scoreboard.
// Ports: i_clk, i_reset (sync, active-low); i_rs_addr/o_rs_data/o_rs_busy
//        (NRD read ports); i_wr_en/i_wr_addr/i_wr_data (NWR write ports);
//        i_iss_valid/i_iss_rd/o_iss_ready (issue); o_busy_vec, o_busy_cnt.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int XLEN   = RF_XLEN,
    parameter int NREG   = RF_NREG,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    // Derived from NREG; not meant to be overridden.
    parameter int AW     = rf_aw(NREG)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NRD*AW-1:0] i_rs_addr,
    output logic [NRD*XLEN-1:0] o_rs_data,
    output logic [NRD-1:0]    o_rs_busy,
    input  logic [NWR-1:0]    i_wr_en,
    input  logic [NWR*AW-1:0] i_wr_addr,
    input  logic [NWR*XLEN-1:0] i_wr_data,
    input  logic              i_iss_valid,
    input  logic [AW-1:0]     i_iss_rd,
    output logic              o_iss_ready,
    output logic [NREG-1:0]   o_busy_vec,
    output logic [AW:0]       o_busy_cnt
);

    logic [XLEN-1:0] w_regs [NREG];
    logic            w_wsel [NWR+1][NREG];
    logic [XLEN-1:0] w_wdat [NWR+1][NREG];
    logic [NREG-1:0] w_busy_vec;

    // Write select chain: each later port overrides earlier ones.
    for (genvar gr = 0; gr < NREG; gr++) begin : g_wr_init
        assign w_wsel[0][gr] = 1'b0;
        assign w_wdat[0][gr] = '0;
    end

    for (genvar gw = 0; gw < NWR; gw++) begin : g_wr_port
        for (genvar gr = 0; gr < NREG; gr++) begin : g_wr_reg
            logic w_hit;
            assign w_hit = i_wr_en[gw] && (gr != 0) &&
                           (i_wr_addr[gw*AW +: AW] == AW'(gr));
            assign w_wsel[gw+1][gr] = w_wsel[gw][gr] | w_hit;
            assign w_wdat[gw+1][gr] = w_hit ? i_wr_data[gw*XLEN +: XLEN]
                                            : w_wdat[gw][gr];
        end
    end

    for (genvar gr = 0; gr < NREG; gr++) begin : g_reg
        logic [XLEN-1:0] r_q;
        always_ff @(posedge i_clk) begin
            if (!i_reset)
                r_q <= '0;
            else if (w_wsel[NWR][gr])
                r_q <= w_wdat[NWR][gr];
        end
        assign w_regs[gr] = r_q;
    end

    // Forwarding is suppressed in reset since those writes are dropped.
    for (genvar gk = 0; gk < NRD; gk++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_fwd;

        assign w_addr = i_rs_addr[gk*AW +: AW];

        always_comb begin
            w_fwd  = 1'b0;
            w_data = w_regs[w_addr];
            for (int w = 0; w < NWR; w++) begin
                if (BYPASS != 0 && i_reset && i_wr_en[w] &&
                    i_wr_addr[w*AW +: AW] == w_addr) begin
                    w_fwd  = 1'b1;
                    w_data = i_wr_data[w*XLEN +: XLEN];
                end
            end
            if (w_addr == AW'(RF_ZERO_ADDR)) begin
                w_fwd  = 1'b0;
                w_data = '0;
            end
        end

        assign o_rs_data[gk*XLEN +: XLEN] = w_data;
        assign o_rs_busy[gk] = i_reset & w_busy_vec[w_addr] & ~w_fwd;
    end

    rf_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR),
        .AW   (AW)
    ) u_sb (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_iss_valid (i_iss_valid),
        .i_iss_rd    (i_iss_rd),
        .o_iss_ready (o_iss_ready),
        .o_busy_vec  (w_busy_vec),
        .o_busy_cnt  (o_busy_cnt)
    );

    assign o_busy_vec = w_busy_vec;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised + directed bench for regfile_sb against an array/bit-list model.
// Ports exercised: all read, write, issue and scoreboard outputs.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NRD*AW-1:0] rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]    rs_busy;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic              iss_valid;
    logic [AW-1:0]     iss_rd;
    logic              iss_ready;
    logic [NREG-1:0]   busy_vec;
    logic [AW:0]       busy_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0] m_mem [NREG];
    bit              m_busy [NREG];

    regfile_sb #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (1)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_rs_addr   (rs_addr),
        .o_rs_data   (rs_data),
        .o_rs_busy   (rs_busy),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_iss_valid (iss_valid),
        .i_iss_rd    (iss_rd),
        .o_iss_ready (iss_ready),
        .o_busy_vec  (busy_vec),
        .o_busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int wa(input int w);
        return int'(wr_addr[w*AW +: AW]);
    endfunction

    // Highest enabled write port targeting a, or -1.
    function automatic int m_fwd(input int a);
        int h = -1;
        if (!rst_n || a == 0) return -1;
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && wa(w) == a) h = w;
        return h;
    endfunction

    function automatic logic [XLEN-1:0] m_rdata(input int a);
        int h = m_fwd(a);
        if (a == 0) return '0;
        if (h >= 0) return wr_data[h*XLEN +: XLEN];
        return m_mem[a];
    endfunction

    function automatic bit m_rbusy(input int a);
        return rst_n && a != 0 && m_busy[a] && m_fwd(a) < 0;
    endfunction

    function automatic bit m_ready();
        int rd = int'(iss_rd);
        bit hit = 1'b0;
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && wa(w) == rd) hit = 1'b1;
        return rst_n && (rd == 0 || !m_busy[rd] || hit);
    endfunction

    function automatic logic [NREG-1:0] m_vec();
        logic [NREG-1:0] v;
        for (int r = 0; r < NREG; r++) v[r] = m_busy[r];
        return v;
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int r = 0; r < NREG; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    task automatic m_step();
        bit rdy;
        bit clr [NREG];
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                m_mem[r]  = '0;
                m_busy[r] = 1'b0;
            end
            return;
        end
        rdy = m_ready();
        for (int r = 0; r < NREG; r++) clr[r] = 1'b0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wa(w) != 0) begin
                m_mem[wa(w)] = wr_data[w*XLEN +: XLEN];
                clr[wa(w)]   = 1'b1;
            end
        end
        for (int r = 0; r < NREG; r++)
            if (clr[r]) m_busy[r] = 1'b0;
        if (iss_valid && rdy && iss_rd != 0)
            m_busy[iss_rd] = 1'b1;
    endtask

    // Compare everything mid-cycle, then advance model and DUT together.
    task automatic cycle();
        int a;
        @(negedge clk);
        for (int k = 0; k < NRD; k++) begin
            a = int'(rs_addr[k*AW +: AW]);
            chk("rs_data", rs_data[k*XLEN +: XLEN], m_rdata(a));
            chk("rs_busy", rs_busy[k], m_rbusy(a));
        end
        chk("iss_ready", iss_ready, m_ready());
        chk("busy_vec", busy_vec, m_vec());
        chk("busy_cnt", busy_cnt, m_cnt());
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int w, input bit en, input int a,
                          input logic [XLEN-1:0] d);
        wr_en[w]              = en;
        wr_addr[w*AW +: AW]   = AW'(a);
        wr_data[w*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int k, input int a);
        rs_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic no_wr();
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
    endtask

    task automatic rnd_addr(output int a);
        a = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7))
                                        : int'($urandom_range(0, NREG-1));
    endtask

    initial begin
        int a;
        rst_n     = 1'b0;
        rs_addr   = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        no_wr();
        @(posedge clk);
        #1;
        m_step();

        // Preload, then reset with issue attempts held high.
        rst_n = 1'b1;
        set_wr(0, 1'b1, 5, 32'hA5A5_0005);
        set_wr(1, 1'b1, 6, 32'h5A5A_0006);
        cycle();
        no_wr();
        set_rd(0, 5);
        set_rd(1, 6);
        rst_n     = 1'b0;
        iss_valid = 1'b1;
        iss_rd    = AW'(4);
        cycle();
        #1;
        chk("t1_x5", rs_data[31:0], 32'h0);
        chk("t1_x6", rs_data[63:32], 32'h0);
        chk("t1_ready", iss_ready, 1'b0);
        chk("t1_cnt", busy_cnt, 6'd0);
        cycle();
        rst_n     = 1'b1;
        iss_valid = 1'b0;

        // Write + bypass, then x0 write ignored.
        set_wr(0, 1'b1, 5, 32'hDEAD_BEEF);
        set_rd(0, 5);
        #1;
        chk("t2_bypass", rs_data[31:0], 32'hDEAD_BEEF);
        cycle();
        no_wr();
        #1;
        chk("t2_x5", rs_data[31:0], 32'hDEAD_BEEF);
        set_wr(0, 1'b1, 0, 32'h1234);
        set_rd(1, 0);
        cycle();
        no_wr();
        set_rd(0, 0);
        #1;
        chk("t2_x0", rs_data[31:0], 32'h0);

        // Same-address writes: higher port wins.
        set_wr(0, 1'b1, 7, 32'h11);
        set_wr(1, 1'b1, 7, 32'h22);
        cycle();
        no_wr();
        set_rd(0, 7);
        #1;
        chk("t3_x7", rs_data[31:0], 32'h22);

        // Issue, blocked reissue, busy read, writeback clear.
        iss_valid = 1'b1;
        iss_rd    = AW'(9);
        cycle();
        set_rd(0, 9);
        #1;
        chk("t4_ready", iss_ready, 1'b0);
        chk("t4_cnt", busy_cnt, 6'd1);
        chk("t4_vec9", busy_vec[9], 1'b1);
        chk("t4_rsbusy", rs_busy[0], 1'b1);
        cycle();
        iss_valid = 1'b0;
        set_wr(1, 1'b1, 9, 32'h55);
        cycle();
        no_wr();
        #1;
        chk("t4_clr_cnt", busy_cnt, 6'd0);
        chk("t4_x9", rs_data[31:0], 32'h55);

        // Writeback and reissue of the same register in one cycle.
        iss_valid = 1'b1;
        iss_rd    = AW'(3);
        cycle();
        set_wr(1, 1'b1, 3, 32'h33);
        #1;
        chk("t5_ready", iss_ready, 1'b1);
        cycle();
        no_wr();
        iss_valid = 1'b0;
        set_rd(0, 3);
        #1;
        chk("t5_vec3", busy_vec[3], 1'b1);
        chk("t5_cnt", busy_cnt, 6'd1);
        chk("t5_x3", rs_data[31:0], 32'h33);
        set_wr(0, 1'b1, 3, 32'h0);
        cycle();
        no_wr();

        // Fill the scoreboard, then reset mid-sequence.
        for (int i = 1; i < NREG; i++) begin
            iss_valid = 1'b1;
            iss_rd    = AW'(i);
            cycle();
        end
        iss_valid = 1'b0;
        #1;
        chk("t6_full", busy_cnt, 6'd31);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        #1;
        chk("t6_rst_cnt", busy_cnt, 6'd0);
        chk("t6_rst_vec", busy_vec, 32'h0);
        for (int i = 1; i <= 12; i++) begin
            iss_valid = 1'b1;
            iss_rd    = AW'(i);
            rst_n     = (i != 7);
            cycle();
        end
        rst_n     = 1'b1;
        iss_valid = 1'b0;
        #1;
        chk("t6_mid_cnt", busy_cnt, 6'd5);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            for (int w = 0; w < NWR; w++) begin
                rnd_addr(a);
                set_wr(w, $urandom_range(0, 1) != 0, a, $urandom);
            end
            for (int k = 0; k < NRD; k++) begin
                rnd_addr(a);
                set_rd(k, a);
            end
            rnd_addr(a);
            iss_valid = ($urandom_range(0, 1) != 0);
            iss_rd    = AW'(a);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
